// File: rtl/fw_boot_loader_pkg.sv
// Shared constants and state encoding for the firmware boot loader.
// Address and data widths match the 6502 bus that the loader feeds.
package fw_boot_loader_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int REG_WIDTH  = 8;

    localparam logic [15:0] INSTRUCTION_BASE  = 16'h8000;
    localparam logic [15:0] RESET_VECTOR_ADDR = 16'hFFFC;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        VEC_LO,
        VEC_HI,
        HOLD,
        DONE,
        ERROR
    } boot_state_t;

endpackage

// File: rtl/fw_boot_loader.sv
// Streams a firmware image into memory, writes the reset vector, then releases the CPU.
// Every output is a register and is assigned in the same block as the state.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, CPU held in reset, waiting for start
// LOAD   | accepting image bytes, one memory write per accepted byte
// VEC_LO | writing LOAD_BASE low byte to VECTOR_ADDR
// VEC_HI | writing LOAD_BASE high byte to VECTOR_ADDR+1
// HOLD   | keeping CPU in reset for HOLD_CYCLES cycles
// DONE   | CPU released; start reloads
// ERROR  | image reached the vector address; CPU held in reset
module fw_boot_loader
    import fw_boot_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = fw_boot_loader_pkg::ADDR_WIDTH,
    parameter int                    REG_WIDTH   = fw_boot_loader_pkg::REG_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] LOAD_BASE   = fw_boot_loader_pkg::INSTRUCTION_BASE,
    parameter logic [ADDR_WIDTH-1:0] VECTOR_ADDR = fw_boot_loader_pkg::RESET_VECTOR_ADDR,
    parameter int                    HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [REG_WIDTH-1:0]  in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_din,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] byte_count
);

    localparam logic [REG_WIDTH-1:0]  VEC_LO_BYTE = LOAD_BASE[REG_WIDTH-1:0];
    localparam logic [REG_WIDTH-1:0]  VEC_HI_BYTE = REG_WIDTH'(LOAD_BASE >> REG_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] VEC_HI_ADDR = VECTOR_ADDR + ADDR_WIDTH'(1);
    localparam logic [7:0]            HOLD_LOAD   = 8'(HOLD_CYCLES);

    boot_state_t           state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [7:0]            hold_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            hold_cnt    <= '0;
            in_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            cpu_reset_n <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            byte_count  <= '0;
        end else begin
            mem_we <= 1'b0;

            // start is honoured only in the three non-busy states
            if (start && (state == IDLE || state == DONE || state == ERROR)) begin
                state       <= LOAD;
                wr_ptr      <= LOAD_BASE;
                byte_count  <= '0;
                in_ready    <= 1'b1;
                busy        <= 1'b1;
                cpu_reset_n <= 1'b0;
                done        <= 1'b0;
                error       <= 1'b0;
            end else begin
                unique case (state)
                    LOAD: begin
                        if (in_valid && in_ready) begin
                            // the overflow check comes before the increment, so the pointer never wraps
                            if (wr_ptr == VECTOR_ADDR) begin
                                state    <= ERROR;
                                in_ready <= 1'b0;
                                busy     <= 1'b0;
                                error    <= 1'b1;
                            end else begin
                                mem_we     <= 1'b1;
                                mem_addr   <= wr_ptr;
                                mem_din    <= in_data;
                                wr_ptr     <= wr_ptr + ADDR_WIDTH'(1);
                                byte_count <= byte_count + ADDR_WIDTH'(1);
                                if (in_last) begin
                                    state    <= VEC_LO;
                                    in_ready <= 1'b0;
                                end
                            end
                        end
                    end
                    VEC_LO: begin
                        mem_we   <= 1'b1;
                        mem_addr <= VECTOR_ADDR;
                        mem_din  <= VEC_LO_BYTE;
                        state    <= VEC_HI;
                    end
                    VEC_HI: begin
                        mem_we   <= 1'b1;
                        mem_addr <= VEC_HI_ADDR;
                        mem_din  <= VEC_HI_BYTE;
                        hold_cnt <= HOLD_LOAD;
                        state    <= HOLD;
                    end
                    HOLD: begin
                        if (hold_cnt == 8'd1) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            cpu_reset_n <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt - 8'd1;
                        end
                    end
                    IDLE, DONE, ERROR: begin
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fw_boot_loader.sv
// Bench for fw_boot_loader: expected memory writes are queued as images are sent,
// and a negedge monitor pops and compares each write the loader presents.
module tb_fw_boot_loader;
    import fw_boot_loader_pkg::*;

    localparam logic [15:0] BASE = 16'hFFF0;
    localparam logic [15:0] VEC  = 16'hFFFC;
    localparam int          HOLD_N = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        cpu_reset_n;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] byte_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    logic [7:0]  img[$];

    fw_boot_loader #(
        .ADDR_WIDTH (16),
        .REG_WIDTH  (8),
        .LOAD_BASE  (BASE),
        .VECTOR_ADDR(VEC),
        .HOLD_CYCLES(HOLD_N)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .cpu_reset_n(cpu_reset_n),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && mem_we === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_addr, mem_din);
            end else begin
                check("write_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                check("write_data", 32'(mem_din), 32'(exp_data_q.pop_front()));
            end
        end
    end

    task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready %b, expected 1 within 20 cycles", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // queues the image writes plus both vector bytes, then streams img with gap idle cycles per byte
    task automatic load_image(input int gap);
        for (int i = 0; i < img.size(); i++) push_exp(BASE + 16'(i), img[i]);
        push_exp(VEC, BASE[7:0]);
        push_exp(VEC + 16'd1, BASE[15:8]);
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i], (i == img.size() - 1));
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_release();
        int   n;
        int   k;
        logic found;
        n = 0;
        found = 1'b0;
        while (n < 20 && !found) begin
            @(negedge clk);
            n++;
            if (mem_we === 1'b1 && mem_addr === VEC + 16'd1) found = 1'b1;
        end
        check("vec_hi_write_seen", 32'(found), 32'd1);
        k = 0;
        while (k < 20 && cpu_reset_n !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        check("release_delay", 32'(k), 32'(HOLD_N));
        check("done_at_release", 32'(done), 32'd1);
        check("busy_at_release", 32'(busy), 32'd0);
        check("error_at_release", 32'(error), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_din"}, 32'(mem_din), 32'd0);
        check({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_byte_count"}, 32'(byte_count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000, expected finish");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        #13;
        check_reset_values("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // basic three-byte image
        pulse_start();
        check("load_busy", 32'(busy), 32'd1);
        check("load_in_ready", 32'(in_ready), 32'd1);
        img = '{8'hA9, 8'h42, 8'h85};
        load_image(0);
        wait_release();
        check("img1_byte_count", 32'(byte_count), 32'd3);

        // start in DONE drops the CPU reset next cycle, then a gapped five-byte image
        pulse_start();
        check("restart_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        check("restart_done", 32'(done), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_byte_count", 32'(byte_count), 32'd0);
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        load_image(2);
        wait_release();
        check("gapped_byte_count", 32'(byte_count), 32'd5);

        // start during LOAD must not clear progress
        pulse_start();
        push_exp(BASE, 8'hC1);
        push_exp(BASE + 16'd1, 8'hC2);
        push_exp(BASE + 16'd2, 8'hC3);
        push_exp(VEC, BASE[7:0]);
        push_exp(VEC + 16'd1, BASE[15:8]);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        pulse_start();
        check("start_in_load_count", 32'(byte_count), 32'd2);
        check("start_in_load_busy", 32'(busy), 32'd1);
        send_byte(8'hC3, 1'b1);
        wait_release();
        check("start_in_load_final_count", 32'(byte_count), 32'd3);

        // single-byte image
        pulse_start();
        img = '{8'hEA};
        load_image(0);
        wait_release();
        check("one_byte_count", 32'(byte_count), 32'd1);

        // reset pulsed after two bytes, then reload from the base
        pulse_start();
        push_exp(BASE, 8'h01);
        push_exp(BASE + 16'd1, 8'h02);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_values("midload_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        pulse_start();
        img = '{8'h5A, 8'h6B, 8'h7C};
        load_image(0);
        wait_release();
        check("reload_byte_count", 32'(byte_count), 32'd3);

        // image runs into the vector address without in_last
        pulse_start();
        for (int i = 0; i < 12; i++) push_exp(BASE + 16'(i), 8'(i + 16));
        for (int i = 0; i < 13; i++) send_byte(8'(i + 16), 1'b0);
        check("overflow_error", 32'(error), 32'd1);
        check("overflow_in_ready", 32'(in_ready), 32'd0);
        check("overflow_busy", 32'(busy), 32'd0);
        check("overflow_done", 32'(done), 32'd0);
        check("overflow_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("overflow_error_held", 32'(error), 32'd1);
        check("overflow_done_held", 32'(done), 32'd0);
        check("overflow_cpu_reset_n_held", 32'(cpu_reset_n), 32'd0);

        // start leaves ERROR and a fresh image completes
        pulse_start();
        check("error_exit_error", 32'(error), 32'd0);
        check("error_exit_in_ready", 32'(in_ready), 32'd1);
        img = '{8'h99};
        load_image(0);
        wait_release();
        check("after_error_count", 32'(byte_count), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("pending_writes", 32'(exp_addr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fw_boot_loader.md
# fw_boot_loader

Firmware boot loader sitting directly upstream of `cpu_top` and `mem`. It accepts a firmware image as a byte stream, writes it into memory starting at `INSTRUCTION_BASE`, writes the 6502 reset vector (`$FFFC/$FFFD`) to point at the image, then releases the CPU's reset. It is the synthesizable replacement for back-door memory override when preloading programs.

## Interface
Parameters:
- `ADDR_WIDTH`, `` `ADDR_WIDTH `` (16): memory address width.
- `REG_WIDTH`, `` `REG_WIDTH `` (8): data width.
- `LOAD_BASE`, `` `INSTRUCTION_BASE ``: first image byte address; also the reset vector value.
- `VECTOR_ADDR`, 16'hFFFC: reset vector low-byte address. The high byte goes to `VECTOR_ADDR+1`.
- `HOLD_CYCLES`, 4: cycles `cpu_reset_n` stays low after the vector is written (range 1..255).

Ports (clock and reset first):
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a load.
- `in_valid` in 1: image byte valid.
- `in_data` in `REG_WIDTH`: image byte.
- `in_last` in 1: qualifies the final image byte.
- `in_ready` out 1: loader accepts a byte when `in_valid && in_ready`.
- `mem_we` out 1: memory write enable, feeding `mem.we` through the top-level mux.
- `mem_addr` out `ADDR_WIDTH`: write address.
- `mem_din` out `REG_WIDTH`: write data.
- `cpu_reset_n` out 1: reset to `cpu_top`.
- `busy` out 1: high in any state other than IDLE, DONE, or ERROR.
- `done` out 1: image loaded and CPU released.
- `error` out 1: image overflowed the load region.
- `byte_count` out `ADDR_WIDTH`: number of image bytes accepted.

## Operation
- FSM states: IDLE → LOAD → VEC_LO → VEC_HI → HOLD → DONE, plus ERROR.
- **IDLE:** `cpu_reset_n`=0 and `in_ready`=0. On `start`, clear `byte_count`, set the write pointer to `LOAD_BASE`, and go to LOAD.
- **LOAD:** `in_ready`=1.
  - Each accepted byte is written to the write pointer. The pointer and `byte_count` then increment.
  - An accepted byte with `in_last`=1 goes to VEC_LO.
  - If a byte is accepted while the pointer equals `VECTOR_ADDR`, it is not written. The FSM goes to ERROR.
- **VEC_LO:** write `LOAD_BASE[7:0]` to `VECTOR_ADDR`. **VEC_HI:** write `LOAD_BASE[15:8]` to `VECTOR_ADDR+1`. Each takes one cycle. `in_ready`=0 in both.
- **HOLD:** count `HOLD_CYCLES` cycles with `cpu_reset_n`=0, then go to DONE.
- **DONE:** `cpu_reset_n`=1 and `done`=1.
  - `start` re-enters LOAD. `cpu_reset_n` drops to 0 the next cycle and `done` clears.
- **ERROR:**
  - `error`=1, `cpu_reset_n`=0, and `in_ready`=0.
  - Only `start` (restart the load) or `reset_n` leaves this state.
- `start` is ignored while `busy`=1.
- `mem_we` is never asserted outside LOAD, VEC_LO, and VEC_HI.

## Timing
- **Reset values (async):** state IDLE; `cpu_reset_n`=0; `in_ready`, `mem_we`, `done`, `error`, `busy`=0; `mem_addr`, `mem_din`, `byte_count`=0.
- All outputs are registered.
- **Byte writes:** a byte accepted at edge N shows `mem_we`/`mem_addr`/`mem_din` valid in cycle N+1, one write per cycle. A byte can be accepted every cycle.
- `in_ready` is driven from state only. It has no combinational path from `in_valid`.
- **Last byte to vector writes:** if the last byte is accepted at edge N, the vector-low write is visible in cycle N+2 and the vector-high write in cycle N+3.
- **Release:** `cpu_reset_n` rises `HOLD_CYCLES` cycles after the vector-high write. `done` rises in the same cycle.
- **Pointer width:** the pointer is `ADDR_WIDTH` bits. Wrap-around is impossible because the overflow check precedes the increment.
- **Reset mid-load:** `reset_n` asserted in any state returns all outputs to their reset values immediately. A partial image stays in memory.

## Structure
- Shared package:
  - `INSTRUCTION_BASE`, `ADDR_WIDTH`, `REG_WIDTH`, and `RESET_VECTOR_ADDR` (16'hFFFC).
  - `boot_state_t` enum (IDLE, LOAD, VEC_LO, VEC_HI, HOLD, DONE, ERROR).
- Single module, with no sub-module.
- The HOLD counter is an 8-bit down-counter inside the module.
- The top level muxes `mem_we`/`mem_addr`/`mem_din` against CPU bus access while `cpu_reset_n`=0.

## Test plan
- Reset, then `start`, then 3 bytes 8'hA9, 8'h42, 8'h85 (`in_last` on the third).
  - Memory holds them at `LOAD_BASE`..`LOAD_BASE+2`.
  - `$FFFC`/`$FFFD` = `LOAD_BASE` low/high bytes.
  - `byte_count`=3, `done`=1, and `cpu_reset_n` rises exactly `HOLD_CYCLES`=4 cycles after the vector-high write.
- Gapped `in_valid` (one byte every third cycle) with a 5-byte image → identical memory contents. `mem_we` pulses only once per accepted byte.
- Image of `VECTOR_ADDR-LOAD_BASE+1` bytes with no early `in_last`:
  - `error`=1 on the overflowing byte, and `$FFFC` is unwritten.
  - `cpu_reset_n` stays 0, and `done`=0.
- `reset_n` pulsed low during LOAD after 2 bytes → all outputs return to reset values at once. `cpu_reset_n`=0, and a new `start` reloads from `LOAD_BASE`.
- `start` pulsed during LOAD → ignored, `byte_count` is not cleared. `start` in DONE → `cpu_reset_n`=0 the next cycle and a second image loads correctly.
- A 1-byte image with `in_last` on the first byte → vector written, `byte_count`=1, `done`=1.
